// File: rtl/room_controller_if.sv
// Shared types and the button/status bundle of the adventure game sequencer.
//
// room_controller_pkg
//   room_state_type : 3-bit room encoding r_0 (Cave) .. r_6 (Graveyard).
//
// room_controller_if : signals exchanged with the room controller.
//   n, s, e, w      : direction buttons (level; the controller edge-detects them).
//   founded_sword   : sword-held flag coming back from the sword tracker.
//   room            : current room.
//   win, dead       : victory / graveyard status.
//   moves           : number of accepted moves.
//   moved           : one-cycle pulse after an accepted move.
//   modport master  : stimulus side (buttons, sword flag).
//   modport slave   : controller side.

package room_controller_pkg;
    typedef enum logic [2:0] {
        r_0 = 3'd0,  // Cave
        r_1 = 3'd1,  // Tunnel
        r_2 = 3'd2,  // River
        r_3 = 3'd3,  // Sword Stash
        r_4 = 3'd4,  // Dragon's Den
        r_5 = 3'd5,  // Victory
        r_6 = 3'd6   // Graveyard
    } room_state_type;
endpackage

interface room_controller_if;
    import room_controller_pkg::*;

    logic           n;
    logic           s;
    logic           e;
    logic           w;
    logic           founded_sword;
    room_state_type room;
    logic           win;
    logic           dead;
    logic [7:0]     moves;
    logic           moved;

    modport master (
        output n, s, e, w, founded_sword,
        input  room, win, dead, moves, moved
    );

    modport slave (
        input  n, s, e, w, founded_sword,
        output room, win, dead, moves, moved
    );
endinterface

// File: rtl/room_controller.sv
// Adventure game sequencer: tracks the player's room from edge-detected
// direction buttons, resolves the Dragon's Den with the sword flag and
// kills the player once the move budget is spent outside the dungeon end.
//
// Ports
//   clk   : system clock, all state changes on posedge.
//   reset : asynchronous, active-high.
//   bus   : room_controller_if.slave (buttons, sword flag, room/status outputs).
// Parameters
//   MAX_MOVES : accepted moves allowed before a timeout death (1..255).

module room_controller
    import room_controller_pkg::*;
#(
    parameter int unsigned MAX_MOVES = 32
) (
    input  logic          clk,
    input  logic          reset,
    room_controller_if.slave bus
);

    localparam logic [7:0] MAX_MOVES_C = MAX_MOVES[7:0];

    // Button vector bit order is {n, s, e, w}.
    localparam logic [3:0] P_N = 4'b1000;
    localparam logic [3:0] P_S = 4'b0100;
    localparam logic [3:0] P_E = 4'b0010;
    localparam logic [3:0] P_W = 4'b0001;

    logic [3:0]     btn_s;
    logic [3:0]     pulse_s;
    logic           single_s;
    logic           timeout_s;
    logic           accept_s;
    room_state_type room_next_s;
    logic [7:0]     moves_next_s;

    logic [3:0]     btn_q_r;
    // A button only counts once it has been seen low after reset, so a
    // button held through reset release cannot fake a press.
    logic [3:0]     arm_r;
    room_state_type room_r;
    logic [7:0]     moves_r;
    logic           moved_r;
    logic           win_r;
    logic           dead_r;

    // Rising-edge detection and single-press qualification.
    always_comb begin
        btn_s     = {bus.n, bus.s, bus.e, bus.w};
        pulse_s   = btn_s & ~btn_q_r & arm_r;
        single_s  = (pulse_s != 4'd0) && ((pulse_s & (pulse_s - 4'd1)) == 4'd0);
        timeout_s = (moves_r == MAX_MOVES_C) &&
                    (room_r inside {r_0, r_1, r_2, r_3});
    end

    // Next-room decode: timeout first, then the room map.
    always_comb begin
        room_next_s = room_r;
        accept_s    = 1'b0;
        if (timeout_s) begin
            room_next_s = r_6;
            accept_s    = 1'b0;
        end else begin
            case (room_r)
                r_0: begin
                    if (single_s && (pulse_s == P_E)) begin
                        room_next_s = r_1;
                        accept_s    = 1'b1;
                    end else begin
                        room_next_s = room_r;
                        accept_s    = 1'b0;
                    end
                end
                r_1: begin
                    if (single_s && (pulse_s == P_S)) begin
                        room_next_s = r_2;
                        accept_s    = 1'b1;
                    end else if (single_s && (pulse_s == P_W)) begin
                        room_next_s = r_0;
                        accept_s    = 1'b1;
                    end else begin
                        room_next_s = room_r;
                        accept_s    = 1'b0;
                    end
                end
                r_2: begin
                    if (single_s && (pulse_s == P_W)) begin
                        room_next_s = r_3;
                        accept_s    = 1'b1;
                    end else if (single_s && (pulse_s == P_E)) begin
                        room_next_s = r_4;
                        accept_s    = 1'b1;
                    end else begin
                        room_next_s = room_r;
                        accept_s    = 1'b0;
                    end
                end
                r_3: begin
                    if (single_s && (pulse_s == P_E)) begin
                        room_next_s = r_2;
                        accept_s    = 1'b1;
                    end else begin
                        room_next_s = room_r;
                        accept_s    = 1'b0;
                    end
                end
                // The dragon resolves on the edge after arrival; not a move.
                r_4: begin
                    if (bus.founded_sword) begin
                        room_next_s = r_5;
                    end else begin
                        room_next_s = r_6;
                    end
                    accept_s = 1'b0;
                end
                r_5, r_6: begin
                    room_next_s = room_r;
                    accept_s    = 1'b0;
                end
                // Unused encoding: fall back to the start room.
                default: begin
                    room_next_s = r_0;
                    accept_s    = 1'b0;
                end
            endcase
        end
    end

    // Move counter saturates at 255.
    always_comb begin
        moves_next_s = moves_r;
        if (accept_s && (moves_r != 8'd255)) begin
            moves_next_s = moves_r + 8'd1;
        end else begin
            moves_next_s = moves_r;
        end
    end

    // Button history and arming flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q_r <= 4'd0;
            arm_r   <= 4'd0;
        end else begin
            btn_q_r <= btn_s;
            arm_r   <= arm_r | ~btn_s;
        end
    end

    // Game state and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            room_r  <= r_0;
            moves_r <= 8'd0;
            moved_r <= 1'b0;
            win_r   <= 1'b0;
            dead_r  <= 1'b0;
        end else begin
            room_r  <= room_next_s;
            moves_r <= moves_next_s;
            moved_r <= accept_s;
            win_r   <= (room_next_s == r_5);
            dead_r  <= (room_next_s == r_6);
        end
    end

    assign bus.room  = room_r;
    assign bus.moves = moves_r;
    assign bus.moved = moved_r;
    assign bus.win   = win_r;
    assign bus.dead  = dead_r;

endmodule

// File: tb/tb_room_controller.sv
// Self-checking bench for room_controller. Two instances: u_a with the
// default move budget, u_b with MAX_MOVES=4 for the timeout scenario.
// Each instance has a small sword-tracker model (flag set one cycle after
// the room is r_3, cleared by reset).

module tb_room_controller;

    typedef struct packed {
        logic [2:0] room;
        logic [7:0] moves;
        logic       moved;
        logic       win;
        logic       dead;
    } obs_t;

    typedef struct packed {
        logic [3:0] btn;   // {n, s, e, w}
        logic [2:0] room;
        logic [7:0] moves;
        logic       moved;
    } vec_t;

    localparam logic [3:0] B0 = 4'b0000;
    localparam logic [3:0] BN = 4'b1000;
    localparam logic [3:0] BS = 4'b0100;
    localparam logic [3:0] BE = 4'b0010;
    localparam logic [3:0] BW = 4'b0001;

    logic clk;
    logic reset;
    logic sword_a;
    logic sword_b;
    int   errors;
    int   checks;
    obs_t sb_q[$];

    room_controller_if bus_a ();
    room_controller_if bus_b ();

    room_controller #(.MAX_MOVES(32)) u_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    room_controller #(.MAX_MOVES(4))  u_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sword tracker models.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sword_a <= 1'b0;
        else if (bus_a.room == 3'd3) sword_a <= 1'b1;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sword_b <= 1'b0;
        else if (bus_b.room == 3'd3) sword_b <= 1'b1;
    end
    assign bus_a.founded_sword = sword_a;
    assign bus_b.founded_sword = sword_b;

    function automatic obs_t expect_of(input logic [2:0] room, input logic [7:0] moves,
                                       input logic moved);
        obs_t o;
        o.room  = room;
        o.moves = moves;
        o.moved = moved;
        o.win   = (room == 3'd5);
        o.dead  = (room == 3'd6);
        return o;
    endfunction

    function automatic obs_t observe(input bit sel);
        obs_t o;
        if (sel) o = {bus_b.room, bus_b.moves, bus_b.moved, bus_b.win, bus_b.dead};
        else     o = {bus_a.room, bus_a.moves, bus_a.moved, bus_a.win, bus_a.dead};
        return o;
    endfunction

    task automatic drive(input bit sel, input logic [3:0] btn);
        if (sel) begin
            {bus_b.n, bus_b.s, bus_b.e, bus_b.w} = btn;
            {bus_a.n, bus_a.s, bus_a.e, bus_a.w} = 4'b0000;
        end else begin
            {bus_a.n, bus_a.s, bus_a.e, bus_a.w} = btn;
            {bus_b.n, bus_b.s, bus_b.e, bus_b.w} = 4'b0000;
        end
    endtask

    // Drive one vector between edges, queue its expectation, then wait
    // until just after the edge that should produce it.
    task automatic drive_step(input bit sel, input vec_t v);
        @(negedge clk);
        drive(sel, v.btn);
        sb_q.push_back(expect_of(v.room, v.moves, v.moved));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, B0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t exp_o, got;
        reset = 1'b1;
        drive(1'b0, B0);
        #3;
        for (int k = 0; k < 2; k++) begin
            sb_q.push_back(expect_of(3'd0, 8'd0, 1'b0));
            exp_o = sb_q.pop_front();
            got   = observe(k[0]);
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL reset dut%0d: got room=%0d moves=%0d moved=%0b win=%0b dead=%0b, expected room=%0d moves=%0d moved=%0b win=%0b dead=%0b",
                         k, got.room, got.moves, got.moved, got.win, got.dead,
                         exp_o.room, exp_o.moves, exp_o.moved, exp_o.win, exp_o.dead);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_win_path();
        obs_t exp_o, got;
        vec_t tbl [12] = '{
            '{B0, 3'd0, 8'd0, 1'b0}, '{BE, 3'd1, 8'd1, 1'b1}, '{B0, 3'd1, 8'd1, 1'b0},
            '{BS, 3'd2, 8'd2, 1'b1}, '{B0, 3'd2, 8'd2, 1'b0}, '{BW, 3'd3, 8'd3, 1'b1},
            '{B0, 3'd3, 8'd3, 1'b0}, '{BE, 3'd2, 8'd4, 1'b1}, '{B0, 3'd2, 8'd4, 1'b0},
            '{BE, 3'd4, 8'd5, 1'b1}, '{B0, 3'd5, 8'd5, 1'b0}, '{BE, 3'd5, 8'd5, 1'b0}};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive_step(1'b0, tbl[i]);
            exp_o = sb_q.pop_front();
            got   = observe(1'b0);
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL win_path step %0d: got room=%0d moves=%0d moved=%0b win=%0b dead=%0b, expected room=%0d moves=%0d moved=%0b win=%0b dead=%0b",
                         i, got.room, got.moves, got.moved, got.win, got.dead,
                         exp_o.room, exp_o.moves, exp_o.moved, exp_o.win, exp_o.dead);
            end
        end
    endtask

    task automatic test_no_sword();
        obs_t exp_o, got;
        vec_t tbl [10] = '{
            '{B0, 3'd0, 8'd0, 1'b0}, '{BE, 3'd1, 8'd1, 1'b1}, '{B0, 3'd1, 8'd1, 1'b0},
            '{BS, 3'd2, 8'd2, 1'b1}, '{B0, 3'd2, 8'd2, 1'b0}, '{BE, 3'd4, 8'd3, 1'b1},
            '{B0, 3'd6, 8'd3, 1'b0}, '{BN, 3'd6, 8'd3, 1'b0}, '{B0, 3'd6, 8'd3, 1'b0},
            '{BE, 3'd6, 8'd3, 1'b0}};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive_step(1'b0, tbl[i]);
            exp_o = sb_q.pop_front();
            got   = observe(1'b0);
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL no_sword step %0d: got room=%0d moves=%0d moved=%0b win=%0b dead=%0b, expected room=%0d moves=%0d moved=%0b win=%0b dead=%0b",
                         i, got.room, got.moves, got.moved, got.win, got.dead,
                         exp_o.room, exp_o.moves, exp_o.moved, exp_o.win, exp_o.dead);
            end
        end
    endtask

    task automatic test_held_button();
        obs_t exp_o, got;
        vec_t v;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i == 0)       v = '{B0, 3'd0, 8'd0, 1'b0};
            else if (i == 1)  v = '{BE, 3'd1, 8'd1, 1'b1};
            else if (i < 11)  v = '{BE, 3'd1, 8'd1, 1'b0};
            else              v = '{B0, 3'd1, 8'd1, 1'b0};
            drive_step(1'b0, v);
            exp_o = sb_q.pop_front();
            got   = observe(1'b0);
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL held_button step %0d: got room=%0d moves=%0d moved=%0b, expected room=%0d moves=%0d moved=%0b",
                         i, got.room, got.moves, got.moved, exp_o.room, exp_o.moves, exp_o.moved);
            end
        end
    endtask

    task automatic test_invalid_moves();
        obs_t exp_o, got;
        vec_t tbl [6] = '{
            '{B0, 3'd0, 8'd0, 1'b0}, '{BE | BW, 3'd0, 8'd0, 1'b0}, '{B0, 3'd0, 8'd0, 1'b0},
            '{BN, 3'd0, 8'd0, 1'b0}, '{B0, 3'd0, 8'd0, 1'b0}, '{BE, 3'd1, 8'd1, 1'b1}};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_step(1'b0, tbl[i]);
            exp_o = sb_q.pop_front();
            got   = observe(1'b0);
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL invalid_moves step %0d: got room=%0d moves=%0d moved=%0b, expected room=%0d moves=%0d moved=%0b",
                         i, got.room, got.moves, got.moved, exp_o.room, exp_o.moves, exp_o.moved);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t exp_o, got;
        vec_t tbl [10] = '{
            '{B0, 3'd0, 8'd0, 1'b0}, '{BE, 3'd1, 8'd1, 1'b1}, '{B0, 3'd1, 8'd1, 1'b0},
            '{BW, 3'd0, 8'd2, 1'b1}, '{B0, 3'd0, 8'd2, 1'b0}, '{BE, 3'd1, 8'd3, 1'b1},
            '{B0, 3'd1, 8'd3, 1'b0}, '{BW, 3'd0, 8'd4, 1'b1}, '{BE, 3'd6, 8'd4, 1'b0},
            '{B0, 3'd6, 8'd4, 1'b0}};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive_step(1'b1, tbl[i]);
            exp_o = sb_q.pop_front();
            got   = observe(1'b1);
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL timeout step %0d: got room=%0d moves=%0d moved=%0b dead=%0b, expected room=%0d moves=%0d moved=%0b dead=%0b",
                         i, got.room, got.moves, got.moved, got.dead,
                         exp_o.room, exp_o.moves, exp_o.moved, exp_o.dead);
            end
        end
    endtask

    task automatic test_reset_mid_game();
        obs_t exp_o, got;
        vec_t pre [6] = '{
            '{B0, 3'd0, 8'd0, 1'b0}, '{BE, 3'd1, 8'd1, 1'b1}, '{B0, 3'd1, 8'd1, 1'b0},
            '{BS, 3'd2, 8'd2, 1'b1}, '{B0, 3'd2, 8'd2, 1'b0}, '{BW, 3'd3, 8'd3, 1'b1}};
        vec_t post [5] = '{
            '{BE, 3'd0, 8'd0, 1'b0}, '{BE, 3'd0, 8'd0, 1'b0}, '{BE, 3'd0, 8'd0, 1'b0},
            '{B0, 3'd0, 8'd0, 1'b0}, '{BE, 3'd1, 8'd1, 1'b1}};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_step(1'b0, pre[i]);
            exp_o = sb_q.pop_front();
            got   = observe(1'b0);
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL reset_mid pre step %0d: got room=%0d moves=%0d, expected room=%0d moves=%0d",
                         i, got.room, got.moves, exp_o.room, exp_o.moves);
            end
        end
        // Hold e and pulse reset between edges.
        @(negedge clk);
        drive(1'b0, BE);
        #2;
        reset = 1'b1;
        #1;
        sb_q.push_back(expect_of(3'd0, 8'd0, 1'b0));
        exp_o = sb_q.pop_front();
        got   = observe(1'b0);
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL reset_mid async: got room=%0d moves=%0d moved=%0b, expected room=%0d moves=%0d moved=%0b",
                     got.room, got.moves, got.moved, exp_o.room, exp_o.moves, exp_o.moved);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_step(1'b0, post[i]);
            exp_o = sb_q.pop_front();
            got   = observe(1'b0);
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL reset_mid post step %0d: got room=%0d moves=%0d moved=%0b, expected room=%0d moves=%0d moved=%0b",
                         i, got.room, got.moves, got.moved, exp_o.room, exp_o.moves, exp_o.moved);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_win_path();
        test_no_sword();
        test_held_button();
        test_invalid_moves();
        test_timeout();
        test_reset_mid_game();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
